// File: rtl/digit_sprite_layer.sv
// N-digit decimal sprite overlay: BCD conversion of a handshaked value, frame-boundary commit,
// 3-stage pixel pipeline. Optional macro LEADING_ZERO_BLANK_EN hides leading zero digits.
module digit_sprite_layer #(
  parameter int unsigned SPR_W      = 50,
  parameter int unsigned SPR_H      = 50,
  parameter int unsigned N_DIGITS   = 4,
  parameter int unsigned VAL_W      = 14,
  parameter int unsigned SCALE_LOG2 = 0,
  parameter int unsigned POS_X      = 0,
  parameter int unsigned POS_Y      = 0,
  parameter int unsigned IDX_W      = 2,
  parameter int unsigned COMMIT_Y   = 480,
  localparam int unsigned ADDR_W    = $clog2(10 * SPR_W * SPR_H)
) (
  input  logic              vga_clk,
  input  logic              reset_n,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic              blank,
  input  logic [3:0]        bg_red,
  input  logic [3:0]        bg_green,
  input  logic [3:0]        bg_blue,
  input  logic [VAL_W-1:0]  val_data,
  input  logic              val_valid,
  output logic              val_ready,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [IDX_W-1:0]  rom_q,
  output logic [IDX_W-1:0]  pal_idx,
  input  logic [3:0]        pal_red,
  input  logic [3:0]        pal_green,
  input  logic [3:0]        pal_blue,
  output logic [3:0]        red,
  output logic [3:0]        green,
  output logic [3:0]        blue
);

  localparam int unsigned BOX_W   = (N_DIGITS * SPR_W) << SCALE_LOG2;
  localparam int unsigned BOX_H   = SPR_H << SCALE_LOG2;
  localparam int unsigned SUB_W   = (SCALE_LOG2 > 0) ? SCALE_LOG2 : 1;
  localparam int unsigned SUB_MAX = (1 << SCALE_LOG2) - 1;
  localparam int unsigned COL_W   = (SPR_W > 1) ? $clog2(SPR_W) : 1;
  localparam int unsigned DIG_W   = $clog2(N_DIGITS) + 1;
  localparam int unsigned BCD_W   = 4 * N_DIGITS;
  localparam int unsigned CNT_W   = $clog2(VAL_W + 1);

  function automatic longint unsigned pow10(input int unsigned n);
    longint unsigned p;
    p = 1;
    for (int unsigned i = 0; i < n; i++) p = p * 10;
    return p;
  endfunction

  localparam longint unsigned SAT_LIMIT = pow10(N_DIGITS);

  typedef enum logic [1:0] {StIdle, StConv, StPend} state_t;

  state_t             r_state, w_state_nxt;
  logic [VAL_W-1:0]   r_bin;
  logic [BCD_W-1:0]   r_bcd, w_bcd_adj, w_bcd_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_sat;
  logic [BCD_W-1:0]   r_disp;
  logic               w_accept, w_step, w_commit, w_commit_pt;
  logic [63:0]        w_val64;

  logic [SUB_W-1:0]   r_sub, w_sub, w_sub_nxt;
  logic [COL_W-1:0]   r_col, w_col, w_col_nxt;
  logic [DIG_W-1:0]   r_dig, w_dig, w_dig_nxt;
  logic               w_origin, w_in_box, w_vis;
  logic [31:0]        w_x32, w_y32, w_row;
  logic [3:0]         w_dig_val;
  logic [ADDR_W-1:0]  w_rom_addr, r_rom_addr;
  logic               r_vis1, r_vis2, r_blank1, r_blank2;
  logic [11:0]        r_bg1, r_bg2;

  // Column/digit counters track the current pixel; DrawX==POS_X forces them to zero.
  assign w_origin = (DrawX == 10'(POS_X));
  always_comb begin
    w_sub     = w_origin ? '0 : r_sub;
    w_col     = w_origin ? '0 : r_col;
    w_dig     = w_origin ? '0 : r_dig;
    w_sub_nxt = w_sub + SUB_W'(1);
    w_col_nxt = w_col;
    w_dig_nxt = w_dig;
    if (w_sub == SUB_W'(SUB_MAX)) begin
      w_sub_nxt = '0;
      if (w_col == COL_W'(SPR_W - 1)) begin
        w_col_nxt = '0;
        w_dig_nxt = w_dig + DIG_W'(1);
      end else begin
        w_col_nxt = w_col + COL_W'(1);
      end
    end
  end

  assign w_x32    = 32'(DrawX);
  assign w_y32    = 32'(DrawY);
  assign w_row    = (w_y32 - POS_Y) >> SCALE_LOG2;
  assign w_in_box = (w_x32 >= POS_X) && (w_x32 < POS_X + BOX_W) && (w_x32 < 32'd640) &&
                    (w_y32 >= POS_Y) && (w_y32 < POS_Y + BOX_H);

  // Display position 0 is the most significant digit.
  always_comb begin
    w_dig_val = '0;
    for (int d = 0; d < N_DIGITS; d++) begin
      if (int'(w_dig) == d) w_dig_val = r_disp[4*(N_DIGITS-1-d) +: 4];
    end
  end

  assign w_rom_addr = ADDR_W'(32'(w_dig_val) * (SPR_W * SPR_H) + w_row * SPR_W + 32'(w_col));

`ifdef LEADING_ZERO_BLANK_EN
  logic [N_DIGITS-1:0] w_lz;
  logic                w_lz_run, w_lz_hit;
  always_comb begin
    w_lz_run = 1'b1;
    w_lz     = '0;
    w_lz_hit = 1'b0;
    for (int d = 0; d < N_DIGITS; d++) begin
      w_lz_run = w_lz_run && (r_disp[4*(N_DIGITS-1-d) +: 4] == 4'd0);
      w_lz[d]  = w_lz_run && (d != N_DIGITS - 1);
      if (int'(w_dig) == d && w_lz[d]) w_lz_hit = 1'b1;
    end
  end
  assign w_vis = w_in_box && !w_lz_hit;
`else
  assign w_vis = w_in_box;
`endif

  assign rom_addr = r_rom_addr;
  assign pal_idx  = r_vis2 ? rom_q : '0;

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sub      <= '0;
      r_col      <= '0;
      r_dig      <= '0;
      r_rom_addr <= '0;
      r_vis1     <= 1'b0;
      r_vis2     <= 1'b0;
      r_blank1   <= 1'b0;
      r_blank2   <= 1'b0;
      r_bg1      <= '0;
      r_bg2      <= '0;
      red        <= '0;
      green      <= '0;
      blue       <= '0;
    end else begin
      r_sub      <= w_sub_nxt;
      r_col      <= w_col_nxt;
      r_dig      <= w_dig_nxt;
      r_rom_addr <= w_rom_addr;
      r_vis1     <= w_vis;
      r_vis2     <= r_vis1;
      r_blank1   <= blank;
      r_blank2   <= r_blank1;
      r_bg1      <= {bg_red, bg_green, bg_blue};
      r_bg2      <= r_bg1;
      if (!r_blank2) begin
        {red, green, blue} <= '0;
      end else if (pal_idx != '0) begin
        {red, green, blue} <= {pal_red, pal_green, pal_blue};
      end else begin
        {red, green, blue} <= r_bg2;
      end
    end
  end

  // Value path: capture, double-dabble, then wait for the commit pixel.
  assign w_commit_pt = (DrawX == 10'd0) && (DrawY == 10'(COMMIT_Y));
  assign w_val64     = 64'(val_data);

  always_comb begin
    for (int i = 0; i < N_DIGITS; i++) begin
      w_bcd_adj[4*i +: 4] = (r_bcd[4*i +: 4] >= 4'd5) ? r_bcd[4*i +: 4] + 4'd3 : r_bcd[4*i +: 4];
    end
    w_bcd_nxt = BCD_W'({w_bcd_adj, r_bin[VAL_W-1]});
  end

  always_comb begin
    w_state_nxt = r_state;
    val_ready   = 1'b0;
    w_accept    = 1'b0;
    w_step      = 1'b0;
    w_commit    = 1'b0;
    unique case (r_state)
      StIdle: begin
        val_ready = 1'b1;
        if (val_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = StConv;
        end
      end
      StConv: begin
        w_step = 1'b1;
        if (r_cnt == CNT_W'(VAL_W - 1)) w_state_nxt = StPend;
      end
      StPend: begin
        if (w_commit_pt) begin
          w_commit    = 1'b1;
          w_state_nxt = StIdle;
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_bin  <= '0;
      r_bcd  <= '0;
      r_cnt  <= '0;
      r_sat  <= 1'b0;
      r_disp <= '0;
    end else begin
      if (w_accept) begin
        r_bin <= val_data;
        r_bcd <= '0;
        r_cnt <= '0;
        r_sat <= (w_val64 >= SAT_LIMIT);
      end
      if (w_step) begin
        r_bin <= r_bin << 1;
        r_bcd <= w_bcd_nxt;
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if (w_commit) begin
        r_disp <= r_sat ? {N_DIGITS{4'h9}} : r_bcd;
      end
    end
  end

endmodule

// File: tb/tb_digit_sprite_layer.sv
// Scoreboard bench for digit_sprite_layer: a default instance and a scaled/offset instance
// share pixel and value stimulus; expected values are queued by the driver, checked by a monitor.
module tb_digit_sprite_layer;

  logic        vga_clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [9:0]  DrawX, DrawY;
  logic        blank;
  logic [3:0]  bg_red, bg_green, bg_blue;
  logic [13:0] val_data;
  logic        val_valid;

  logic        val_ready0, val_ready1;
  logic [14:0] rom_addr0, rom_addr1;
  logic [1:0]  rom_q0 = 2'd0, rom_q1 = 2'd0;
  logic [1:0]  pal_idx0, pal_idx1;
  logic [3:0]  pal_red0, pal_green0, pal_blue0, pal_red1, pal_green1, pal_blue1;
  logic [3:0]  red0, green0, blue0, red1, green1, blue1;

  always #5 vga_clk = ~vga_clk;

  assign bg_red   = DrawX[3:0];
  assign bg_green = DrawY[3:0];
  assign bg_blue  = 4'hA;

  // ROM content: palette index = low two address bits; palette is a fixed mapping.
  always @(posedge vga_clk) rom_q0 <= rom_addr0[1:0];
  always @(posedge vga_clk) rom_q1 <= rom_addr1[1:0];
  assign {pal_red0, pal_green0, pal_blue0} = {2'b10, pal_idx0, pal_idx0, 2'b01, ~pal_idx0, pal_idx0};
  assign {pal_red1, pal_green1, pal_blue1} = {2'b10, pal_idx1, pal_idx1, 2'b01, ~pal_idx1, pal_idx1};

  digit_sprite_layer #(
    .SPR_W(50), .SPR_H(50), .N_DIGITS(4), .VAL_W(14), .SCALE_LOG2(0),
    .POS_X(0), .POS_Y(0), .IDX_W(2), .COMMIT_Y(480)
  ) dut0 (
    .vga_clk(vga_clk), .reset_n(reset_n), .DrawX(DrawX), .DrawY(DrawY), .blank(blank),
    .bg_red(bg_red), .bg_green(bg_green), .bg_blue(bg_blue),
    .val_data(val_data), .val_valid(val_valid), .val_ready(val_ready0),
    .rom_addr(rom_addr0), .rom_q(rom_q0), .pal_idx(pal_idx0),
    .pal_red(pal_red0), .pal_green(pal_green0), .pal_blue(pal_blue0),
    .red(red0), .green(green0), .blue(blue0)
  );

  digit_sprite_layer #(
    .SPR_W(50), .SPR_H(50), .N_DIGITS(4), .VAL_W(14), .SCALE_LOG2(1),
    .POS_X(100), .POS_Y(50), .IDX_W(2), .COMMIT_Y(480)
  ) dut1 (
    .vga_clk(vga_clk), .reset_n(reset_n), .DrawX(DrawX), .DrawY(DrawY), .blank(blank),
    .bg_red(bg_red), .bg_green(bg_green), .bg_blue(bg_blue),
    .val_data(val_data), .val_valid(val_valid), .val_ready(val_ready1),
    .rom_addr(rom_addr1), .rom_q(rom_q1), .pal_idx(pal_idx1),
    .pal_red(pal_red1), .pal_green(pal_green1), .pal_blue(pal_blue1),
    .red(red1), .green(green1), .blue(blue1)
  );

  typedef struct {
    int due;
    int kind;
    int exp;
  } chk_t;

  chk_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   exp_dig[4];

  always @(posedge vga_clk) cyc <= cyc + 1;

  task automatic push(input int kind, input int exp, input int due);
    chk_t c;
    c.due  = due;
    c.kind = kind;
    c.exp  = exp;
    sb.push_back(c);
  endtask

  function automatic logic [11:0] pal_rgb(input logic [1:0] i);
    return {2'b10, i, i, 2'b01, ~i, i};
  endfunction

  function automatic bit lz(input int d);
`ifdef LEADING_ZERO_BLANK_EN
    bit z;
    z = 1'b1;
    for (int k = 0; k <= d; k++) z = z && (exp_dig[k] == 0);
    return z && (d != 3);
`else
    return 1'b0;
`endif
  endfunction

  task automatic set_exp(input int v);
    if (v >= 10000) begin
      for (int k = 0; k < 4; k++) exp_dig[k] = 9;
    end else begin
      exp_dig[0] = v / 1000;
      exp_dig[1] = (v / 100) % 10;
      exp_dig[2] = (v / 10) % 10;
      exp_dig[3] = v % 10;
    end
  endtask

  // kinds: 0/1 = dut0 rgb/addr, 2/3 = dut1 rgb/addr, 4/5 = dut0/dut1 val_ready
  task automatic model(input int dut, input int x, input int y, input bit b);
    int px, py, s, rx, ry, c, dg, col, row, addr;
    bit inb;
    logic [1:0]  idx;
    logic [11:0] rgb;
    logic [9:0]  xv, yv;
    px  = (dut != 0) ? 100 : 0;
    py  = (dut != 0) ? 50 : 0;
    s   = (dut != 0) ? 1 : 0;
    rx  = x - px;
    ry  = y - py;
    inb = (rx >= 0) && (rx < (200 << s)) && (ry >= 0) && (ry < (50 << s)) && (x < 640);
    idx = 2'd0;
    if (inb) begin
      c    = rx >> s;
      dg   = c / 50;
      col  = c % 50;
      row  = ry >> s;
      addr = exp_dig[dg] * 2500 + row * 50 + col;
      idx  = 2'(addr % 4);
      if (lz(dg)) idx = 2'd0;
      push(dut * 2 + 1, addr, cyc + 1);
    end
    xv  = 10'(x);
    yv  = 10'(y);
    rgb = !b ? 12'h000 : ((idx != 2'd0) ? pal_rgb(idx) : {xv[3:0], yv[3:0], 4'hA});
    push(dut * 2, int'(rgb), cyc + 3);
  endtask

  task automatic pix(input int x, input int y, input bit b);
    DrawX = 10'(x);
    DrawY = 10'(y);
    blank = b;
    model(0, x, y, b);
    model(1, x, y, b);
    @(posedge vga_clk);
    #1;
  endtask

  task automatic tick_nochk();
    DrawX = 10'd700;
    DrawY = 10'd500;
    blank = 1'b0;
    @(posedge vga_clk);
    #1;
  endtask

  task automatic scan_line(input int y, input bit b);
    for (int x = 0; x <= 520; x++) pix(x, y, b);
  endtask

  task automatic scan_frame();
    scan_line(0, 1'b1);
    scan_line(25, 1'b1);
    scan_line(49, 1'b1);
    scan_line(51, 1'b1);
    scan_line(149, 1'b1);
  endtask

  task automatic send(input int v);
    int k;
    val_data  = 14'(v);
    val_valid = 1'b1;
    k = 0;
    while (!val_ready0 && k < 50) begin
      pix(700, 500, 1'b0);
      k++;
    end
    if (k >= 50) push(4, 1, cyc);
    pix(700, 500, 1'b0);
    val_valid = 1'b0;
    for (int i = 0; i < 15; i++) begin
      push(4, 0, cyc);
      push(5, 0, cyc);
      pix(700, 500, 1'b0);
    end
  endtask

  task automatic commit(input int v);
    push(4, 0, cyc);
    push(5, 0, cyc);
    pix(0, 480, 1'b0);
    set_exp(v);
    push(4, 1, cyc);
    push(5, 1, cyc);
    pix(700, 500, 1'b0);
  endtask

  always @(negedge vga_clk) begin
    int i;
    logic [31:0] act;
    string nm;
    i = 0;
    while (i < sb.size()) begin
      if (sb[i].due <= cyc) begin
        case (sb[i].kind)
          0: begin act = 32'({red0, green0, blue0}); nm = "rgb0"; end
          1: begin act = 32'(rom_addr0); nm = "rom_addr0"; end
          2: begin act = 32'({red1, green1, blue1}); nm = "rgb1"; end
          3: begin act = 32'(rom_addr1); nm = "rom_addr1"; end
          4: begin act = 32'(val_ready0); nm = "val_ready0"; end
          default: begin act = 32'(val_ready1); nm = "val_ready1"; end
        endcase
        n_vec++;
        if (sb[i].due < cyc || act != 32'(sb[i].exp)) begin
          n_err++;
          $display("FAIL %s cyc=%0d x=%0d y=%0d got=%0h want=%0h", nm, cyc, DrawX, DrawY, act,
                   sb[i].exp);
        end
        sb.delete(i);
      end else begin
        i++;
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    val_valid = 1'b0;
    val_data  = '0;
    DrawX     = 10'd700;
    DrawY     = 10'd500;
    blank     = 1'b0;
    set_exp(0);
    repeat (2) @(posedge vga_clk);
    #1;
    if (val_ready0 !== 1'b1 || val_ready1 !== 1'b1) begin
      n_err++;
      $display("FAIL val_ready not 1 during reset");
    end
    if ({red0, green0, blue0} !== 12'h000 || {red1, green1, blue1} !== 12'h000) begin
      n_err++;
      $display("FAIL rgb not 0 during reset");
    end
    if (rom_addr0 !== 15'd0 || rom_addr1 !== 15'd0) begin
      n_err++;
      $display("FAIL rom_addr not 0 during reset");
    end
    if (pal_idx0 !== 2'd0 || pal_idx1 !== 2'd0) begin
      n_err++;
      $display("FAIL pal_idx not 0 during reset");
    end
    for (int k = 0; k < 4; k++) push(k, 0, cyc);
    push(4, 1, cyc);
    push(5, 1, cyc);
    tick_nochk();
    reset_n = 1'b1;
    tick_nochk();

    scan_frame();
    scan_line(30, 1'b0);

    send(1234);
    scan_frame();
    commit(1234);
    scan_frame();

    send(12345);
    commit(12345);
    scan_frame();

    send(7);
    commit(7);
    scan_frame();

    // Reset while 77 is mid-conversion: it must never be displayed.
    repeat (4) tick_nochk();
    val_data  = 14'd77;
    val_valid = 1'b1;
    tick_nochk();
    val_valid = 1'b0;
    repeat (5) tick_nochk();
    push(4, 0, cyc);
    push(5, 0, cyc);
    tick_nochk();
    reset_n = 1'b0;
    repeat (2) tick_nochk();
    reset_n = 1'b1;
    push(4, 1, cyc);
    push(5, 1, cyc);
    tick_nochk();
    set_exp(0);
    scan_frame();

    repeat (6) tick_nochk();
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL %0d checks never evaluated", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    if (n_err != 0 || n_vec < 12) begin
      $display("FAIL");
      $fatal(1);
    end
    $display("PASS");
    $finish;
  end

endmodule
